// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the fetch PC of a 4-wide fetch group, drives the four
// instruction-memory read addresses and registers the group into decode-1.
// Handles decode stall, branch redirect (with slot realignment) and halt.
// Optional feature: define FETCH_HALT_LIMIT_EN to halt once the group base PC
// exceeds HALT_LIMIT while advancing.
module fetch_ctrl #(
  parameter int unsigned        PC_W       = 16,
  parameter logic [PC_W-1:0]    RESET_PC   = '0,
  parameter logic [PC_W-1:0]    HALT_LIMIT = PC_W'(100)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt_req,
  output logic [PC_W-1:0] pc_a,
  output logic [PC_W-1:0] pc_b,
  output logic [PC_W-1:0] pc_c,
  output logic [PC_W-1:0] pc_d,
  output logic            fetch_valid,
  output logic [3:0]      slot_mask,
  output logic [PC_W-1:0] d1_pc,
  output logic [3:0]      d1_mask,
  output logic            d1_valid,
  output logic            halted
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] LP_RESET_PC = {RESET_PC[PC_W-1:3], 3'b000};

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [1:0]      r_off;
  logic [PC_W-1:0] r_d1_pc;
  logic [3:0]      r_d1_mask;
  logic            r_d1_valid;

  state_t          w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic [1:0]      w_off_nxt;
  logic [PC_W-1:0] w_d1_pc_nxt;
  logic [3:0]      w_d1_mask_nxt;
  logic            w_d1_valid_nxt;
  logic [3:0]      w_slot_mask;
  logic            w_limit_hit;
  logic            w_unused;

`ifdef FETCH_HALT_LIMIT_EN
  // Limit halt fires only where the group would otherwise advance
  assign w_limit_hit = (r_state == RUN) && !stall && (r_pc > HALT_LIMIT);
  assign w_unused    = redirect_pc[0];
`else
  assign w_limit_hit = 1'b0;
  assign w_unused    = redirect_pc[0] ^ (^HALT_LIMIT);
`endif

  // Slot i is valid when it lies at or beyond the first-valid offset
  assign w_slot_mask = {1'b1, (r_off <= 2'd2), (r_off <= 2'd1), (r_off == 2'd0)};

  assign pc_a        = r_pc;
  assign pc_b        = r_pc + PC_W'(2);
  assign pc_c        = r_pc + PC_W'(4);
  assign pc_d        = r_pc + PC_W'(6);
  assign fetch_valid = (r_state == RUN);
  assign slot_mask   = w_slot_mask;
  assign d1_pc       = r_d1_pc;
  assign d1_mask     = r_d1_mask;
  assign d1_valid    = r_d1_valid;
  assign halted      = (r_state == HALTED);

  // Next-state: halt > redirect > flush bubble > stall > advance
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_off_nxt      = r_off;
    w_d1_pc_nxt    = r_d1_pc;
    w_d1_mask_nxt  = r_d1_mask;
    w_d1_valid_nxt = r_d1_valid;
    if (r_state != HALTED) begin
      if (halt_req || w_limit_hit) begin
        w_state_nxt    = HALTED;
        w_d1_valid_nxt = 1'b0;
      end else if (redirect_valid) begin
        w_state_nxt    = FLUSH;
        w_pc_nxt       = {redirect_pc[PC_W-1:3], 3'b000};
        w_off_nxt      = redirect_pc[2:1];
        w_d1_valid_nxt = 1'b0;
      end else if (r_state == FLUSH) begin
        w_state_nxt    = RUN;
        w_d1_valid_nxt = 1'b0;
      end else if (!stall) begin
        w_d1_pc_nxt    = r_pc;
        w_d1_mask_nxt  = w_slot_mask;
        w_d1_valid_nxt = 1'b1;
        w_pc_nxt       = r_pc + PC_W'(8);
        w_off_nxt      = 2'd0;
      end
    end
  end

  // State, PC and decode-1 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_pc       <= LP_RESET_PC;
      r_off      <= 2'd0;
      r_d1_pc    <= '0;
      r_d1_mask  <= '0;
      r_d1_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_off      <= w_off_nxt;
      r_d1_pc    <= w_d1_pc_nxt;
      r_d1_mask  <= w_d1_mask_nxt;
      r_d1_valid <= w_d1_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus for fetch_ctrl, checked every cycle against
// a behavioural model plus hand-computed literal expectations.
module tb_fetch_ctrl;

  localparam int unsigned     PC_W  = 16;
  localparam logic [15:0]     LIMIT = 16'd100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic [15:0] pc_a, pc_b, pc_c, pc_d, d1_pc;
  logic        fetch_valid, d1_valid, halted;
  logic [3:0]  slot_mask, d1_mask;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl #(.PC_W(PC_W), .RESET_PC(16'h0), .HALT_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .pc_a(pc_a), .pc_b(pc_b), .pc_c(pc_c), .pc_d(pc_d),
    .fetch_valid(fetch_valid), .slot_mask(slot_mask),
    .d1_pc(d1_pc), .d1_mask(d1_mask), .d1_valid(d1_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: what the fetch unit must present, in spec terms
  logic [15:0] m_pc = 16'h0;
  logic [1:0]  m_off = 2'd0;
  logic        m_bubble = 1'b0;
  logic        m_halt = 1'b0;
  logic [15:0] m_d1pc = 16'h0;
  logic [3:0]  m_d1mask = 4'h0;
  logic        m_d1v = 1'b0;
  logic        m_limit;

`ifdef FETCH_HALT_LIMIT_EN
  assign m_limit = !m_bubble && !stall && (m_pc > LIMIT);
`else
  assign m_limit = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 16'h0; m_off <= 2'd0; m_bubble <= 1'b0; m_halt <= 1'b0;
      m_d1pc <= 16'h0; m_d1mask <= 4'h0; m_d1v <= 1'b0;
    end else if (!m_halt) begin
      if (halt_req || m_limit) begin
        m_halt <= 1'b1; m_d1v <= 1'b0;
      end else if (redirect_valid) begin
        m_pc <= redirect_pc - (redirect_pc % 16'd8);
        m_off <= 2'((redirect_pc % 16'd8) / 16'd2);
        m_bubble <= 1'b1; m_d1v <= 1'b0;
      end else if (m_bubble) begin
        m_bubble <= 1'b0; m_d1v <= 1'b0;
      end else if (!stall) begin
        m_d1pc <= m_pc; m_d1mask <= 4'(4'hF << m_off); m_d1v <= 1'b1;
        m_pc <= m_pc + 16'd8; m_off <= 2'd0;
      end
    end
  end

  // Cycle compare on the falling edge
  always @(negedge clk) begin
    chk("pc_a", pc_a, m_pc);
    chk("pc_b", pc_b, m_pc + 16'd2);
    chk("pc_c", pc_c, m_pc + 16'd4);
    chk("pc_d", pc_d, m_pc + 16'd6);
    chk("fetch_valid", fetch_valid, !m_halt && !m_bubble);
    chk("slot_mask", slot_mask, 4'(4'hF << m_off));
    chk("d1_pc", d1_pc, m_d1pc);
    chk("d1_mask", d1_mask, m_d1mask);
    chk("d1_valid", d1_valid, m_d1v);
    chk("halted", halted, m_halt);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pc_a", pc_a, 16'h0);
    chk("rst_fetch_valid", fetch_valid, 1'b1);
    chk("rst_d1_valid", d1_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    tick();
    rst_n = 1'b1;

    // Run without stall
    chk("run0_pc_a", pc_a, 16'h0);
    tick();
    chk("run1_pc_a", pc_a, 16'h8);
    chk("run1_d1_pc", d1_pc, 16'h0);
    chk("run1_d1_mask", d1_mask, 4'hF);
    chk("run1_d1_valid", d1_valid, 1'b1);
    tick();
    chk("run2_pc_a", pc_a, 16'h10);
    chk("run2_d1_pc", d1_pc, 16'h8);

    // Stall three cycles at pc 16
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc_a", pc_a, 16'h10);
      chk("stall_d1_pc", d1_pc, 16'h8);
      chk("stall_fetch_valid", fetch_valid, 1'b1);
    end
    stall = 1'b0;
    tick();
    chk("unstall_pc_a", pc_a, 16'h18);
    chk("unstall_d1_pc", d1_pc, 16'h10);

    // Redirect with realignment
    redirect_valid = 1'b1; redirect_pc = 16'h0046;
    tick();
    redirect_valid = 1'b0;
    chk("flush_fetch_valid", fetch_valid, 1'b0);
    chk("flush_pc_a", pc_a, 16'h0040);
    chk("flush_d1_valid", d1_valid, 1'b0);
    chk("model_pc_flush", m_pc, 16'h0040);
    tick();
    chk("realign_fetch_valid", fetch_valid, 1'b1);
    chk("realign_slot_mask", slot_mask, 4'b1000);
    tick();
    chk("realign_d1_pc", d1_pc, 16'h0040);
    chk("realign_d1_mask", d1_mask, 4'b1000);
    chk("realign_d1_valid", d1_valid, 1'b1);
    chk("next_pc_a", pc_a, 16'h0048);
    chk("next_slot_mask", slot_mask, 4'hF);
    tick();
    chk("next_d1_pc", d1_pc, 16'h0048);
    chk("next_d1_mask", d1_mask, 4'hF);
    chk("model_d1mask", m_d1mask, 4'hF);

    // Redirect while stalled, then halt beats redirect
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0080;
    tick();
    chk("stall_redir_pc_a", pc_a, 16'h0080);
    chk("stall_redir_fetch_valid", fetch_valid, 1'b0);
    stall = 1'b0; halt_req = 1'b1; redirect_pc = 16'h0200;
    tick();
    chk("halt_halted", halted, 1'b1);
    chk("halt_pc_a", pc_a, 16'h0080);
    chk("halt_d1_valid", d1_valid, 1'b0);
    halt_req = 1'b0; redirect_pc = 16'h0300;
    tick();
    tick();
    redirect_valid = 1'b0;
    chk("halt_sticky", halted, 1'b1);
    chk("halt_sticky_pc_a", pc_a, 16'h0080);
    chk("halt_sticky_fetch_valid", fetch_valid, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_halted", halted, 1'b0);

    // Wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 16'hFFF8;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("wrap_pc_a0", pc_a, 16'hFFF8);
    chk("wrap_pc_d", pc_d, 16'hFFFE);
    tick();
`ifdef FETCH_HALT_LIMIT_EN
    chk("wrap_limit_halted", halted, 1'b1);
    chk("wrap_limit_pc_a", pc_a, 16'hFFF8);
`else
    chk("wrap_pc_a1", pc_a, 16'h0000);
    chk("wrap_d1_pc", d1_pc, 16'hFFF8);
`endif

    // Async reset in the middle of a flush bubble
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    tick();
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_pc_a", pc_a, 16'h0);
    chk("async_fetch_valid", fetch_valid, 1'b1);
    chk("async_d1_pc", d1_pc, 16'h0);
    chk("async_d1_valid", d1_valid, 1'b0);
    chk("async_slot_mask", slot_mask, 4'hF);
    chk("async_halted", halted, 1'b0);
    tick();
    rst_n = 1'b1;

    // Advance past the halt limit
    for (int i = 0; i < 13; i++) tick();
    chk("lim_pc_a13", pc_a, 16'd104);
    chk("lim_d1_pc13", d1_pc, 16'd96);
    tick();
`ifdef FETCH_HALT_LIMIT_EN
    chk("lim_halted", halted, 1'b1);
    chk("lim_pc_a", pc_a, 16'd104);
    chk("lim_d1_valid", d1_valid, 1'b0);
`else
    chk("nolim_halted", halted, 1'b0);
    chk("nolim_pc_a", pc_a, 16'd112);
    chk("nolim_d1_pc", d1_pc, 16'd104);
    chk("nolim_d1_valid", d1_valid, 1'b1);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
